// File: rtl/multi_cycle_add_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer. One CHUNK-bit ripple-carry slice
// is reused over NCHUNK cycles, with the carry held in a register between slices.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// RUN    | stepping slice k through the shared adder
// DONE   | result held, out_valid high until out_ready
module multi_cycle_add_ctrl #(
  parameter int WIDTH   = 64,
  parameter int CHUNK   = 16,
  parameter int USE_AOI = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             r_co;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_sum;
  logic [CHUNK:0]   w_c;
  logic             w_co;
  logic             w_last;
  logic             w_accept;

  always_comb begin
    w_a_slice = r_op_a[int'(r_k) * CHUNK +: CHUNK];
    w_b_slice = r_op_b[int'(r_k) * CHUNK +: CHUNK];
  end

  assign w_c[0]   = r_carry;
  assign w_co     = w_c[CHUNK];
  assign w_last   = (r_k == K_LAST);
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // Shared ripple-carry slice; USE_AOI only changes the carry gate structure.
  for (genvar i = 0; i < CHUNK; i++) begin : g_rca
    logic w_p;
    assign w_p      = w_a_slice[i] ^ w_b_slice[i];
    assign w_sum[i] = w_p ^ w_c[i];
    if (USE_AOI != 0) begin : g_aoi
      assign w_c[i+1] = ~(~(w_a_slice[i] & w_b_slice[i]) & ~(w_p & w_c[i]));
    end else begin : g_ao
      assign w_c[i+1] = (w_a_slice[i] & w_b_slice[i]) | (w_p & w_c[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_co     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_op_a   <= in_a;
      r_op_b   <= in_sub ? ~in_b : in_b;
      r_result <= '0;
      r_carry  <= in_sub;
      r_k      <= '0;
      r_co     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_result[int'(r_k) * CHUNK +: CHUNK] <= w_sum;
      r_carry <= w_co;
      if (w_last) begin
        r_co  <= w_co;
        // Sign of the result comes straight from the top slice being written now.
        r_ovf <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                 (w_sum[CHUNK-1] != r_op_a[WIDTH-1]);
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  assign out_sum = r_result;
  assign out_co  = r_co;
  assign out_ovf = r_ovf;

endmodule

// File: tb/tb_multi_cycle_add_ctrl.sv
// Self-checking bench: a 16-bit-slice unit and a single-slice unit, each compared
// every cycle against a queue-based arithmetic model, plus directed literal cases.
module tb_multi_cycle_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid[2];
  logic        in_ready[2];
  logic [63:0] in_a[2];
  logic [63:0] in_b[2];
  logic        in_sub[2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [63:0] out_sum[2];
  logic        out_co[2];
  logic        out_ovf[2];

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt[2];
  logic b2b[2];

  always #5 clk = ~clk;

  typedef struct packed {
    logic        co;
    logic        ovf;
    logic [63:0] sum;
  } exp_t;

  function automatic exp_t ref_fn(input logic [63:0] a, input logic [63:0] b, input logic sub);
    exp_t e;
    logic signed [64:0] sa;
    logic signed [64:0] sb;
    logic signed [64:0] sr;
    logic [64:0] u;
    sa = $signed({a[63], a});
    sb = $signed({b[63], b});
    sr = sub ? (sa - sb) : (sa + sb);
    u  = {1'b0, a} + {1'b0, b};
    e.sum = sr[63:0];
    e.ovf = (sr[64] != sr[63]);
    e.co  = sub ? (a >= b) : u[64];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  multi_cycle_add_ctrl #(.WIDTH(64), .CHUNK(16), .USE_AOI(0)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_sub(in_sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_co(out_co[0]), .out_ovf(out_ovf[0])
  );

  multi_cycle_add_ctrl #(.WIDTH(64), .CHUNK(64), .USE_AOI(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_sub(in_sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1]), .out_co(out_co[1]), .out_ovf(out_ovf[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int NCH = (g == 0) ? 4 : 1;
    exp_t q[$];
    int   cyc = 0;
    int   acc = 0;
    int   last_acc = -1;
    logic mr;
    logic mv;
    logic ev;

    always @(negedge rst_n) q.delete();

    // Model: an op is in flight from its accept edge until its handshake edge.
    always @(posedge clk) begin
      if (!b2b[g]) last_acc = -1;
      if (rst_n) begin
        mr = (q.size() == 0);
        mv = !mr && ((cyc - acc) >= NCH);
        if (mv && out_ready[g]) void'(q.pop_front());
        cyc++;
        if (mr && in_valid[g]) begin
          q.push_back(ref_fn(in_a[g], in_b[g], in_sub[g]));
          acc = cyc;
          acc_cnt[g]++;
          if (b2b[g]) begin
            if (last_acc >= 0)
              chk($sformatf("u%0d_interval", g), 64'(cyc - last_acc), 64'(NCH + 2));
            last_acc = cyc;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        chk($sformatf("u%0d_rst_ready", g), 64'(in_ready[g]), 64'd1);
        chk($sformatf("u%0d_rst_valid", g), 64'(out_valid[g]), 64'd0);
        chk($sformatf("u%0d_rst_sum", g), out_sum[g], 64'd0);
        chk($sformatf("u%0d_rst_flags", g), {62'd0, out_co[g], out_ovf[g]}, 64'd0);
      end else begin
        ev = (q.size() > 0) && ((cyc - acc) >= NCH);
        chk($sformatf("u%0d_valid", g), 64'(out_valid[g]), 64'(ev));
        chk($sformatf("u%0d_ready", g), 64'(in_ready[g]), 64'(q.size() == 0));
        if (ev) begin
          chk($sformatf("u%0d_sum", g), out_sum[g], q[0].sum);
          chk($sformatf("u%0d_co", g), 64'(out_co[g]), 64'(q[0].co));
          chk($sformatf("u%0d_ovf", g), 64'(out_ovf[g]), 64'(q[0].ovf));
        end
      end
    end
  end

  task automatic rand_ops(input int u);
    case ($urandom_range(0, 3))
      0: begin in_a[u] = {$urandom, $urandom}; in_b[u] = {$urandom, $urandom}; end
      1: begin in_a[u] = '1; in_b[u] = 64'($urandom_range(0, 3)); end
      2: begin in_a[u] = {1'b0, {63{1'b1}}}; in_b[u] = {1'b1, 63'd0} + 64'($urandom_range(0, 1)); end
      default: begin in_a[u] = 64'($urandom_range(0, 15)); in_b[u] = 64'($urandom_range(0, 15)); end
    endcase
    if ($urandom_range(0, 1) == 1) begin
      in_a[u] = in_a[u] ^ in_b[u];
    end
    in_sub[u] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int u, input string nm);
    int n = 0;
    @(negedge clk);
    while (!in_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[u]) chk({nm, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_op(input int u, input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic [63:0] es, input logic eco, input logic eovf,
                       input int hold, input int lat, input string nm);
    int n = 0;
    wait_idle(u, nm);
    out_ready[u] = 1'b0;
    in_valid[u] = 1'b1;
    in_a[u] = a;
    in_b[u] = b;
    in_sub[u] = s;
    @(negedge clk);
    while (!out_valid[u] && n < 40) begin
      rand_ops(u);
      in_valid[u] = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!out_valid[u]) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({nm, "_latency"}, 64'(n), 64'(lat));
      chk({nm, "_sum"}, out_sum[u], es);
      chk({nm, "_co"}, 64'(out_co[u]), 64'(eco));
      chk({nm, "_ovf"}, 64'(out_ovf[u]), 64'(eovf));
      for (int i = 0; i < hold; i++) begin
        rand_ops(u);
        in_valid[u] = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk({nm, "_held_ready"}, 64'(in_ready[u]), 64'd0);
      chk({nm, "_held_sum"}, out_sum[u], es);
    end
    in_valid[u] = 1'b0;
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    chk({nm, "_after_valid"}, 64'(out_valid[u]), 64'd0);
    chk({nm, "_after_ready"}, 64'(in_ready[u]), 64'd1);
  endtask

  task automatic run_b2b(input int u, input int nops, input int per);
    int start = acc_cnt[u];
    int n = 0;
    b2b[u] = 1'b1;
    out_ready[u] = 1'b1;
    in_valid[u] = 1'b1;
    while ((acc_cnt[u] - start) < nops && n < nops * per + 50) begin
      rand_ops(u);
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_b2b_count", u), 64'(acc_cnt[u] - start), 64'(nops));
    in_valid[u] = 1'b0;
    repeat (per + 2) @(negedge clk);
    out_ready[u] = 1'b0;
    b2b[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0;
      in_a[u] = '0;
      in_b[u] = '0;
      in_sub[u] = 1'b0;
      out_ready[u] = 1'b0;
      acc_cnt[u] = 0;
      b2b[u] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_ready", 64'(in_ready[0]), 64'd1);
    chk("init_valid", 64'(out_valid[0]), 64'd0);
    chk("init_sum", out_sum[0], 64'd0);

    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 0, 4, "add_carry");
    do_op(0, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0, 4, "sub_borrow");
    do_op(0, 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 0, 4, "sub_noborrow");
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, 4, "add_ovf");
    do_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 4, "sub_ovf");
    do_op(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
          1'b0, 1'b0, 10, 4, "backpressure");
    do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 3, 1, "n1_add_carry");
    do_op(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 1, "n1_sub_ovf");

    // Reset landing in the second RUN cycle, after slice 0 has been written.
    wait_idle(0, "rst_mid");
    in_valid[0] = 1'b1;
    in_a[0] = 64'hDEAD_BEEF_0000_1234;
    in_b[0] = 64'd1;
    in_sub[0] = 1'b0;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_mid_sum", out_sum[0], 64'd0);
    chk("rst_mid_ready", 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0, 0, 4, "post_rst");

    run_b2b(0, 1000, 6);
    run_b2b(1, 1000, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
